switch_wrram: RTL and testbench
===============================

Name: switch_wrram

Overview:
- Write-side counterpart of the SISO decoder's RAM read switch.
- Merges two client write streams (e.g. forward/backward metric writers) onto the single write port of a shared RAM.
- Each client has a one-entry buffer. Round-robin arbitration picks the winner; the RAM write port is registered.
- A frame counter flags completion of a block of FRAME_LEN writes, so the upstream controller can swap RAM ownership.

Parameters:
- DWIDTH, 16, data word width.
- RAM_DEPTH, 3072, RAM words. Address width AW = $clog2(RAM_DEPTH).
- FRAME_LEN, 3072, total granted writes per frame (1..2^16-1).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_client_valid0  in  1  client 0 write request.
- o_client_ready0  out  1  client 0 may present a write.
- i_client_addr0  in  AW  client 0 write address.
- i_client_data0  in  DWIDTH  client 0 write data.
- i_client_valid1, o_client_ready1, i_client_addr1, i_client_data1: same as client 0, for client 1.
- i_frame_clr  in  1  synchronous clear of the frame counter.
- o_we  out  1  RAM write enable (registered).
- o_addr  out  AW  RAM write address (registered).
- o_data  out  DWIDTH  RAM write data (registered).
- o_frame_done  out  1  one-cycle pulse, coincident with the FRAME_LEN-th o_we.

Behaviour:
- Reset (i_rstn=0, asynchronous):
  - o_we=0, o_addr=0, o_data=0, o_frame_done=0.
  - Both buffers empty; last_grant=1, so client 0 wins the first contention.
  - Frame counter=0.
  - Buffered writes are discarded. Ready outputs are 0 during reset and 1 from the first cycle after release.
- Client buffer (per client c):
  - Holds valid bit v_c plus addr/data.
  - o_client_ready_c = !v_c | grant_c (combinational; depends on the other client's v only through the arbiter).
  - Handshake when valid & ready on a rising edge: the buffer loads and v_c=1.
  - If granted with no new handshake, v_c clears.
  - Granted and new handshake in the same cycle: the buffer reloads and v_c stays 1.
  - Valid may not drop before the handshake; addr/data must be held stable while valid & !ready.
- Arbiter (combinational, on v_0/v_1):
  - Only one buffer valid: that client is granted.
  - Both valid: grant the client != last_grant.
  - On each grant, last_grant <= granted id.
  - Neither valid: no grant; last_grant holds.
- Output register:
  - On a grant: o_we<=1 and o_addr/o_data <= the granted buffer contents.
  - Otherwise o_we<=0; o_addr/o_data hold their previous values.
- Latency: handshake at edge t appears as o_we high in cycle t+2, with an uncontended client.
- Throughput:
  - A single active client sustains 1 write/cycle.
  - Both active: strict alternation, 1 write per 2 cycles each; no starvation.
- Write order is preserved per client. No ordering is guaranteed between clients.
- Same address from both clients: both writes are issued; the later-granted one wins in RAM. No merging.
- Frame counter:
  - Increments on every grant, width $clog2(FRAME_LEN+1).
  - When the grant brings it to FRAME_LEN: o_frame_done=1 in the same cycle as that o_we, and the counter wraps to 0.
  - i_frame_clr=1: counter <= 0, taking priority over an increment in that cycle. That cycle's write is still issued but not counted.

Optional Feature:
- Macro SWITCH_WRRAM_ADDR_CHECK_EN.
- Defined:
  - A granted entry with addr >= RAM_DEPTH is consumed (buffer clears, last_grant updates) but produces o_we=0 and is not counted.
  - Sticky output o_addr_err (1 bit, reset 0) is set; it is cleared only by reset or i_frame_clr.
- Undefined:
  - No check and no o_addr_err port. Out-of-range addresses pass to o_addr unchanged.

Decomposition:
- Package switch_pkg holds:
  - function clog2-based AW helper;
  - localparam CLIENT0=0, CLIENT1=1;
  - typedef for the write-request struct {addr, data}.
- One natural sub-module: wr_req_buf (one-entry buffer with valid/ready and grant input), instantiated twice.
- Arbiter, output register and frame counter stay in the top module.

Test Plan:
- Reset release, client 0 alone writes addr 5/data 0xA5A5 at edge t -> o_we=1, o_addr=5, o_data=0xA5A5 in cycle t+2. Then o_we=0; ready stays 1.
- Client 0 streams addr 0..7 back-to-back -> 8 consecutive o_we cycles, addresses 0..7 in order, ready never drops.
- Both clients stream 4 writes each from the same edge (c0 addr 0x10.., c1 addr 0x20..) -> outputs alternate c0,c1,c0,c1…, starting with client 0. Each ready toggles low on alternate cycles; all 8 writes appear.
- FRAME_LEN=4, 6 writes from client 1 -> o_frame_done pulses only with the 4th o_we. Assert i_frame_clr before the 5th, then 4 more writes -> next pulse on the 4th write after the clear.
- Reset asserted mid-stream with both buffers full -> o_we drops immediately. After release, no stale writes appear and client 0 wins the first contention.
- With SWITCH_WRRAM_ADDR_CHECK_EN, RAM_DEPTH=3072, write addr 3072 then 100 -> no o_we for 3072, o_addr_err=1 and held; o_we for 100 follows. i_frame_clr clears o_addr_err.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and request type for the RAM write switch.
package switch_pkg;

  localparam int CLIENT0 = 0;
  localparam int CLIENT1 = 1;

  localparam int DEF_DWIDTH    = 16;
  localparam int DEF_RAM_DEPTH = 3072;

  // Address width for a RAM of 'depth' words; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int DEF_AW = addr_width(DEF_RAM_DEPTH);

  // Write request at the default geometry; parameterized users pass their own type.
  typedef struct packed {
    logic [DEF_AW-1:0]     addr;
    logic [DEF_DWIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wr_req_buf.sv
// wr_req_buf: one-entry client write buffer. Accepts a new request whenever it
// is empty or its current entry is being granted this cycle.
module wr_req_buf
  import switch_pkg::*;
#(
  parameter type req_t = wr_req_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic in_valid,
  output logic in_ready,
  input  req_t in_req,
  input  logic grant,
  output logic buf_valid,
  output req_t buf_req
);

  logic handshake;

  assign in_ready  = en & (~buf_valid | grant);
  assign handshake = in_valid & in_ready;

  // Load on handshake (also when the old entry leaves this cycle); drain on grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid <= 1'b0;
      buf_req   <= '0;
    end else if (handshake) begin
      buf_valid <= 1'b1;
      buf_req   <= in_req;
    end else if (grant) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/switch_wrram.sv
// switch_wrram: merges two client write streams onto one registered RAM write
// port with round-robin arbitration and a frame-completion counter.
// Optional build macro SWITCH_WRRAM_ADDR_CHECK_EN drops out-of-range writes and
// raises the sticky o_addr_err flag.
module switch_wrram
  import switch_pkg::*;
#(
  parameter  int DWIDTH    = 16,
  parameter  int RAM_DEPTH = 3072,
  parameter  int FRAME_LEN = 3072,
  localparam int AW        = addr_width(RAM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_client_valid0,
  output logic              o_client_ready0,
  input  logic [AW-1:0]     i_client_addr0,
  input  logic [DWIDTH-1:0] i_client_data0,
  input  logic              i_client_valid1,
  output logic              o_client_ready1,
  input  logic [AW-1:0]     i_client_addr1,
  input  logic [DWIDTH-1:0] i_client_data1,
  input  logic              i_frame_clr,
  output logic              o_we,
  output logic [AW-1:0]     o_addr,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_frame_done
`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
  ,
  output logic              o_addr_err
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DWIDTH-1:0] data;
  } req_t;

  logic          run_q;
  logic [1:0]    buf_v;
  req_t          buf_q [2];
  req_t          in_req0;
  req_t          in_req1;
  logic [1:0]    grant;
  logic          last_grant;
  logic          any_grant;
  req_t          gnt_req;
  logic          addr_bad;
  logic          issue;
  logic [CW-1:0] frame_cnt;

  assign in_req0 = {i_client_addr0, i_client_data0};
  assign in_req1 = {i_client_addr1, i_client_data1};

  // Hold off ready until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  wr_req_buf #(.req_t(req_t)) u_buf0 (
    .clk       (i_clk),
    .rstn      (i_rstn),
    .en        (run_q),
    .in_valid  (i_client_valid0),
    .in_ready  (o_client_ready0),
    .in_req    (in_req0),
    .grant     (grant[CLIENT0]),
    .buf_valid (buf_v[CLIENT0]),
    .buf_req   (buf_q[CLIENT0])
  );

  wr_req_buf #(.req_t(req_t)) u_buf1 (
    .clk       (i_clk),
    .rstn      (i_rstn),
    .en        (run_q),
    .in_valid  (i_client_valid1),
    .in_ready  (o_client_ready1),
    .in_req    (in_req1),
    .grant     (grant[CLIENT1]),
    .buf_valid (buf_v[CLIENT1]),
    .buf_req   (buf_q[CLIENT1])
  );

  // Round-robin: a lone valid buffer wins; on contention the one not served last wins.
  always_comb begin
    grant = buf_v;
    if (buf_v[CLIENT0] && buf_v[CLIENT1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  assign any_grant = |grant;
  assign gnt_req   = grant[CLIENT1] ? buf_q[CLIENT1] : buf_q[CLIENT0];

`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
  assign addr_bad = int'(gnt_req.addr) >= RAM_DEPTH;
`else
  assign addr_bad = 1'b0;
`endif

  // A dropped out-of-range entry is still consumed, so it still rotates priority.
  assign issue = any_grant & ~addr_bad;

  // Remember which client was served last; reset favours client 0 next.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)        last_grant <= 1'b1;
    else if (any_grant) last_grant <= grant[CLIENT1];
  end

  // Registered RAM write port; address and data hold between writes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_we   <= 1'b0;
      o_addr <= '0;
      o_data <= '0;
    end else begin
      o_we <= issue;
      if (issue) begin
        o_addr <= gnt_req.addr;
        o_data <= gnt_req.data;
      end
    end
  end

  // Frame counter: clear wins over the increment, so a write in the clear cycle is not counted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_cnt    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_frame_clr) begin
        frame_cnt <= '0;
      end else if (issue) begin
        if (frame_cnt == CW'(FRAME_LEN - 1)) begin
          frame_cnt    <= '0;
          o_frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
  // Sticky range error; a new error in a clear cycle is kept rather than lost.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                    o_addr_err <= 1'b0;
    else if (any_grant && addr_bad) o_addr_err <= 1'b1;
    else if (i_frame_clr)           o_addr_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_switch_wrram.sv
// tb_switch_wrram: directed, table-driven and randomized checks of switch_wrram.
module tb_switch_wrram;

  localparam int DW    = 16;
  localparam int DEPTH = 3072;
  localparam int FL    = 4;
  localparam int AW    = 12;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          r0, r1;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          clr = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          done;
`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
  logic          addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int v0, a0, v1, a1;
    int we, ea, r0, r1, done;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  switch_wrram #(.DWIDTH(DW), .RAM_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_client_valid0 (v0),
    .o_client_ready0 (r0),
    .i_client_addr0  (a0),
    .i_client_data0  (d0),
    .i_client_valid1 (v1),
    .o_client_ready1 (r1),
    .i_client_addr1  (a1),
    .i_client_data1  (d1),
    .i_frame_clr     (clr),
    .o_we            (we),
    .o_addr          (addr),
    .o_data          (data),
    .o_frame_done    (done)
`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
    ,
    .o_addr_err      (addr_err)
`endif
  );

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {4'hD, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
    chk("rst_addr_err", addr_err, 0);
`endif
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One client streams nitems back-to-back; done expected on write numbers done_at, done_at+4.
  task automatic stream(input int c, input int nitems, input int base, input int clr_at,
                        input int done_at);
    for (int i = 0; i < nitems + 3; i++) begin
      int wn;
      wn = i - 1;
      if (i >= 2 && i < nitems + 2) begin
        chk("stream_we", we, 1);
        chk("stream_addr", addr, base + i - 2);
        chk("stream_data", data, dat(AW'(base + i - 2)));
        chk("stream_done", done, (wn == done_at || wn == done_at + 4) ? 1 : 0);
      end else begin
        chk("stream_idle_we", we, 0);
        chk("stream_idle_done", done, 0);
      end
      chk("stream_ready", (c == 0) ? r0 : r1, 1);
      if (c == 0) begin
        v0 = (i < nitems); a0 = AW'(base + i); d0 = dat(a0);
      end else begin
        v1 = (i < nitems); a1 = AW'(base + i); d1 = dat(a1);
      end
      clr = (i == clr_at);
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0; clr = 1'b0;
  endtask

  // Randomized traffic against a queue-per-client scoreboard and a frame count model.
  task automatic rand_test(input int cycles);
    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];
    logic [AW+DW-1:0] e;
    int   wcount = 0, st0 = 0, st1 = 0, max_st = 0;
    logic hs0, hs1, exp_done;
    for (int n = 0; n < cycles + 8; n++) begin
      exp_done = 1'b0;
      if (we) begin
        if (data[DW-1]) begin
          chk("rand_c1_pending", q1.size() != 0, 1);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("rand_c1_addr", addr, e[AW+DW-1:DW]);
            chk("rand_c1_data", data, e[DW-1:0]);
          end
        end else begin
          chk("rand_c0_pending", q0.size() != 0, 1);
          if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("rand_c0_addr", addr, e[AW+DW-1:DW]);
            chk("rand_c0_data", data, e[DW-1:0]);
          end
        end
        if (!clr) begin
          wcount++;
          if (wcount == FL) begin
            exp_done = 1'b1;
            wcount = 0;
          end
        end
      end
      if (clr) wcount = 0;
      chk("rand_done", done, exp_done);

      hs0 = v0 && r0;
      hs1 = v1 && r1;
      if (hs0) q0.push_back({a0, d0});
      if (hs1) q1.push_back({a1, d1});
      st0 = (v0 && !r0) ? st0 + 1 : 0;
      st1 = (v1 && !r1) ? st1 + 1 : 0;
      if (st0 > max_st) max_st = st0;
      if (st1 > max_st) max_st = st1;

      if (n < cycles) begin
        if (!v0 || hs0) begin
          v0 = ($urandom_range(0, 3) != 0);
          a0 = AW'($urandom_range(0, DEPTH - 1));
          d0 = {1'b0, (DW-1)'($urandom)};
        end
        if (!v1 || hs1) begin
          v1 = ($urandom_range(0, 3) != 0);
          a1 = AW'($urandom_range(0, DEPTH - 1));
          d1 = {1'b1, (DW-1)'($urandom)};
        end
        clr = ($urandom_range(0, 15) == 0);
      end else begin
        if (hs0) v0 = 1'b0;
        if (hs1) v1 = 1'b0;
        clr = 1'b0;
      end
      @(negedge clk);
    end
    chk("rand_q0_drained", q0.size(), 0);
    chk("rand_q1_drained", q1.size(), 0);
    chk("rand_max_stall_le1", max_st <= 1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Both clients stream 4 writes from the same edge; outputs alternate starting with client 0.
    tbl[0]  = '{1, 'h10, 1, 'h20, 0, 0,    1, 1, 0};
    tbl[1]  = '{1, 'h11, 1, 'h21, 0, 0,    1, 0, 0};
    tbl[2]  = '{1, 'h12, 1, 'h21, 1, 'h10, 0, 1, 0};
    tbl[3]  = '{1, 'h12, 1, 'h22, 1, 'h20, 1, 0, 0};
    tbl[4]  = '{1, 'h13, 1, 'h22, 1, 'h11, 0, 1, 0};
    tbl[5]  = '{1, 'h13, 1, 'h23, 1, 'h21, 1, 0, 1};
    tbl[6]  = '{0, 0,    1, 'h23, 1, 'h12, 0, 1, 0};
    tbl[7]  = '{0, 0,    0, 0,    1, 'h22, 1, 0, 0};
    tbl[8]  = '{0, 0,    0, 0,    1, 'h13, 1, 1, 0};
    tbl[9]  = '{0, 0,    0, 0,    1, 'h23, 1, 1, 1};
    tbl[10] = '{0, 0,    0, 0,    0, 0,    1, 1, 0};

    // Single write latency: handshake edge, then o_we after the following edge.
    do_reset();
    chk("lat_ready0", r0, 1);
    chk("lat_ready1", r1, 1);
    v0 = 1'b1; a0 = AW'(5); d0 = 16'hA5A5;
    @(negedge clk);
    chk("lat_we_early", we, 0);
    v0 = 1'b0;
    @(negedge clk);
    chk("lat_we", we, 1);
    chk("lat_addr", addr, 5);
    chk("lat_data", data, 16'hA5A5);
    @(negedge clk);
    chk("lat_we_after", we, 0);
    chk("lat_ready_after", r0, 1);

    // Client 0 streams addresses 0..7 at full rate.
    do_reset();
    stream(0, 8, 0, -1, 4);

    // Contention table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk("tbl_we", we, tbl[i].we);
      if (tbl[i].we != 0) begin
        chk("tbl_addr", addr, tbl[i].ea);
        chk("tbl_data", data, dat(AW'(tbl[i].ea)));
      end
      chk("tbl_ready0", r0, tbl[i].r0);
      chk("tbl_ready1", r1, tbl[i].r1);
      chk("tbl_done", done, tbl[i].done);
      v0 = tbl[i].v0[0]; a0 = AW'(tbl[i].a0); d0 = dat(a0);
      v1 = tbl[i].v1[0]; a1 = AW'(tbl[i].a1); d1 = dat(a1);
      @(negedge clk);
    end

    // Frame counter: pulse on 4th write, clear while idle, clear coincident with a write.
    do_reset();
    stream(1, 6, 'h30, -1, 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    stream(1, 4, 'h40, -1, 4);
    stream(1, 5, 'h50, 1, 5);

    // Reset mid-stream with both buffers full.
    do_reset();
    v0 = 1'b1; a0 = AW'('h60); d0 = dat(a0);
    v1 = 1'b1; a1 = AW'('h70); d1 = dat(a1);
    @(negedge clk);
    a0 = AW'('h61); d0 = dat(a0);
    a1 = AW'('h71); d1 = dat(a1);
    @(negedge clk);
    chk("mid_we_before", we, 1);
    chk("mid_addr_before", addr, 'h60);
    rstn = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ready0", r0, 0);
    chk("mid_rst_ready1", r1, 0);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_stale", we, 0);
      @(negedge clk);
    end
    v0 = 1'b1; a0 = AW'('h80); d0 = dat(a0);
    v1 = 1'b1; a1 = AW'('h90); d1 = dat(a1);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("mid_first_we", we, 1);
    chk("mid_first_addr", addr, 'h80);
    @(negedge clk);
    chk("mid_second_we", we, 1);
    chk("mid_second_addr", addr, 'h90);
    @(negedge clk);
    chk("mid_idle_we", we, 0);

    // Out-of-range address 3072 followed by 100.
    do_reset();
    v0 = 1'b1; a0 = AW'(3072); d0 = 16'h1111;
    @(negedge clk);
    a0 = AW'(100); d0 = 16'h2222;
    @(negedge clk);
    v0 = 1'b0;
`ifdef SWITCH_WRRAM_ADDR_CHECK_EN
    chk("range_bad_we", we, 0);
    chk("range_err_set", addr_err, 1);
    @(negedge clk);
    chk("range_good_we", we, 1);
    chk("range_good_addr", addr, 100);
    chk("range_err_held", addr_err, 1);
    @(negedge clk);
    chk("range_err_still", addr_err, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("range_err_cleared", addr_err, 0);
`else
    chk("range_pass_we", we, 1);
    chk("range_pass_addr", addr, 3072);
    chk("range_pass_data", data, 16'h1111);
    @(negedge clk);
    chk("range_next_we", we, 1);
    chk("range_next_addr", addr, 100);
`endif
    @(negedge clk);

    // Randomized traffic.
    do_reset();
    rand_test(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
